batcharger_adcseq: RTL

ADC front-end sequencer for the battery charger. It sits directly upstream of the charger control FSM. It takes that FSM's `imonen`, `vmonen` and `tmonen` requests and time-multiplexes one external 8-bit ADC across the battery voltage, current and temperature channels. It registers each result and produces the `vbat`, `ibat`, `tbat` and `vtok` inputs the charger controller consumes.

---
 rtl/batcharger_pkg.sv | 64 ++++++
 rtl/batcharger_dcnt.sv | 31 +++
 rtl/batcharger_adcseq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/batcharger_pkg.sv
// Shared definitions for the battery-charger ADC front end: channel
// encodings, sequencer states and the channel round-robin helper.
package batcharger_pkg;

    localparam int ADC_W = 8;   // external ADC word width
    localparam int CNT_W = 8;   // settle/timeout down-counter width

    // Analog mux select encodings; 2'b11 is never driven.
    localparam logic [1:0] CH_V = 2'b00;
    localparam logic [1:0] CH_I = 2'b01;
    localparam logic [1:0] CH_T = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEL   = 2'd1,
        ST_CONV  = 2'd2,
        ST_STORE = 2'd3
    } seq_state_e;

    // Result of a round-robin search: hit is low when no channel is requested.
    typedef struct packed {
        logic       hit;
        logic [1:0] ch;
    } ch_pick_t;

    // Successor in the cyclic order V -> I -> T -> V.
    function automatic logic [1:0] ch_succ(input logic [1:0] ch);
        case (ch)
            CH_V:    return CH_I;
            CH_I:    return CH_T;
            default: return CH_V;
        endcase
    endfunction

    function automatic logic ch_req(input logic [1:0] ch, input logic v,
                                    input logic i, input logic t);
        case (ch)
            CH_V:    return v;
            CH_I:    return i;
            CH_T:    return t;
            default: return 1'b0;
        endcase
    endfunction

    // First requested channel strictly after 'base' in cyclic order; 'base'
    // itself is the last candidate, so a lone channel repeats back-to-back.
    function automatic ch_pick_t pick_next(input logic [1:0] base, input logic v,
                                           input logic i, input logic t);
        ch_pick_t   r;
        logic [1:0] c;
        r.hit = 1'b0;
        r.ch  = CH_V;
        c     = base;
        for (int k = 0; k < 3; k++) begin
            c = ch_succ(c);
            if (!r.hit && ch_req(c, v, i, t)) begin
                r.hit = 1'b1;
                r.ch  = c;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/batcharger_dcnt.sv
// Loadable down-counter with zero flag, shared by the settle and the
// conversion-timeout phases of the ADC sequencer. Saturates at zero.
module batcharger_dcnt
    import batcharger_pkg::*;
(
    input  logic             clk,
    input  logic             rstz,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load takes priority over decrement; hold once zero is reached.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            // NOTE: registers are updated with <= so every flop samples the
            // pre-edge value; blocking = here would create ordering races.
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/batcharger_adcseq.sv
// ADC front-end sequencer: time-multiplexes one 8-bit ADC across the battery
// voltage, current and temperature channels and registers each result for
// the charger controller.
module batcharger_adcseq
    import batcharger_pkg::*;
#(
    parameter int SETTLE  = 4,   // mux settle cycles before adc_start, 1..15
    parameter int TIMEOUT = 63   // max CONV cycles incl. the start cycle, 2..255
) (
    input  logic             clk,
    input  logic             rstz,
    input  logic             en,
    input  logic             imonen,
    input  logic             vmonen,
    input  logic             tmonen,
    input  logic             adc_eoc,
    input  logic [ADC_W-1:0] adc_data,
    output logic [1:0]       adc_sel,
    output logic             adc_start,
    output logic [ADC_W-1:0] vbat,
    output logic [ADC_W-1:0] ibat,
    output logic [ADC_W-1:0] tbat,
    output logic             vtok,
    output logic             adc_err
);

    // Counter reload values: SEL lasts SETTLE cycles, CONV at most TIMEOUT.
    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT - 1);

    seq_state_e       state, state_nxt;
    ch_pick_t         pick;
    logic [1:0]       last_ch;
    logic [ADC_W-1:0] stage;
    logic             vvalid, ivalid, tvalid;

    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;
    logic             start_nxt, sel_load, capture, store, timeout;

    batcharger_dcnt u_dcnt (
        .clk      (clk),
        .rstz     (rstz),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Sequencer state register.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_val   = SETTLE_LD;
        cnt_dec   = 1'b0;
        start_nxt = 1'b0;
        sel_load  = 1'b0;
        capture   = 1'b0;
        store     = 1'b0;
        timeout   = 1'b0;
        // In IDLE resume after the last converted channel, otherwise after
        // the channel currently being converted.
        pick = pick_next((state == ST_IDLE) ? last_ch : adc_sel,
                         vmonen, imonen, tmonen);

        case (state)
            ST_IDLE: begin
                if (en && pick.hit) begin
                    state_nxt = ST_SEL;
                    sel_load  = 1'b1;
                    cnt_load  = 1'b1;
                end
            end
            ST_SEL: begin
                if (cnt_zero) begin
                    state_nxt = ST_CONV;
                    start_nxt = 1'b1;
                    cnt_load  = 1'b1;
                    cnt_val   = TIMEOUT_LD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_CONV: begin
                // adc_eoc is ignored in the start cycle; on the last CONV
                // cycle it still wins over the timeout.
                if (!adc_start && adc_eoc) begin
                    capture   = 1'b1;
                    state_nxt = ST_STORE;
                end else if (cnt_zero) begin
                    timeout   = 1'b1;
                    state_nxt = pick.hit ? ST_SEL : ST_IDLE;
                    sel_load  = pick.hit;
                    cnt_load  = pick.hit;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_STORE: begin
                store     = 1'b1;
                state_nxt = pick.hit ? ST_SEL : ST_IDLE;
                sel_load  = pick.hit;
                cnt_load  = pick.hit;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (!en) state_nxt = ST_IDLE;
    end

    // Mux select, start pulse, staging, result registers and flags.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            // NOTE: the staging register and result registers are reset
            // along with the control flops so no X ever reaches the charger.
            adc_sel   <= CH_V;
            adc_start <= 1'b0;
            stage     <= '0;
            vbat      <= '0;
            ibat      <= '0;
            tbat      <= '0;
            vvalid    <= 1'b0;
            ivalid    <= 1'b0;
            tvalid    <= 1'b0;
            vtok      <= 1'b0;
            adc_err   <= 1'b0;
            last_ch   <= CH_T;
        end else if (!en) begin
            adc_sel   <= CH_V;
            adc_start <= 1'b0;
            stage     <= '0;
            vbat      <= '0;
            ibat      <= '0;
            tbat      <= '0;
            vvalid    <= 1'b0;
            ivalid    <= 1'b0;
            tvalid    <= 1'b0;
            vtok      <= 1'b0;
            adc_err   <= 1'b0;
            last_ch   <= CH_T;
        end else begin
            adc_start <= start_nxt;
            if (sel_load) adc_sel <= pick.ch;
            if (capture)  stage   <= adc_data;
            if (store) begin
                case (adc_sel)
                    CH_V:    begin vbat <= stage; vvalid <= 1'b1; end
                    CH_I:    begin ibat <= stage; ivalid <= 1'b1; end
                    CH_T:    begin tbat <= stage; tvalid <= 1'b1; end
                    default: ;
                endcase
            end
            // A timed-out channel keeps its old data but loses validity.
            if (timeout) begin
                adc_err <= 1'b1;
                case (adc_sel)
                    CH_V:    vvalid <= 1'b0;
                    CH_I:    ivalid <= 1'b0;
                    CH_T:    tvalid <= 1'b0;
                    default: ;
                endcase
            end
            if (store || timeout) last_ch <= adc_sel;
            // Current validity is deliberately excluded from vtok.
            vtok <= vvalid & tvalid;
        end
    end

endmodule
